// File: rtl/acc_alu_pkg.sv
// Shared types and constants for the registered accumulator ALU.
package acc_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LD  = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } opcode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    // Bit positions of the flags inside the packed flag register
    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/acc_alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per step, low half of
// the product register initially holds the multiplier and shifts out LSB-first.
module acc_alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic                 last
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     upper_sum;

    // The step result is exposed combinationally so the final step and the commit share one edge
    always_comb begin
        addend    = prod[0] ? mcand : '0;
        upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod_next = {upper_sum, prod[WIDTH-1:1]};
        last      = (count == CNT_W'(1));
    end

    // Product, multiplicand and iteration counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            mcand <= '0;
            count <= '0;
        end else if (clr) begin
            prod  <= '0;
            mcand <= '0;
            count <= '0;
        end else if (load) begin
            prod  <= {{WIDTH{1'b0}}, b};
            mcand <= a;
            count <= CNT_W'(WIDTH);
        end else if (step) begin
            prod  <= prod_next;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/acc_alu_seq.sv
// Registered accumulator ALU with flags, single-cycle add/sub/logic/shift and
// an iterative multiply behind a start/busy/done handshake.
module acc_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [2:0]       control_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic             busy_out,
    output logic             done_out
);
    import acc_alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [NUM_FLAGS-1:0] CLR_FLAGS = NUM_FLAGS'(1 << FLAG_Z);

    state_e                 state;
    state_e                 next_state;
    opcode_e                op;
    logic [WIDTH-1:0]       acc;
    logic [NUM_FLAGS-1:0]   flags;
    logic                   done;
    logic                   mul_load;
    logic                   mul_step;
    logic                   alu_commit;
    logic                   mul_commit;
    logic [2*WIDTH-1:0]     mul_prod_next;
    logic                   mul_last;
    logic [WIDTH-1:0]       operand;
    logic                   sub_cin;
    logic [WIDTH:0]         add_full;
    logic                   msb_carry_in;
    logic [WIDTH-1:0]       alu_res;
    logic [NUM_FLAGS-1:0]   alu_flags;
    logic [WIDTH-1:0]       mul_res;
    logic [NUM_FLAGS-1:0]   mul_flags;

    assign op = opcode_e'(control_in);

    // Adder shared by ADD and SUB; carry into the MSB recovered from the sum bit
    always_comb begin
        sub_cin      = (op == OP_SUB);
        operand      = sub_cin ? ~b_in : b_in;
        add_full     = {1'b0, acc} + {1'b0, operand} + {{WIDTH{1'b0}}, sub_cin};
        msb_carry_in = add_full[WIDTH-1] ^ acc[WIDTH-1] ^ operand[WIDTH-1];
    end

    // Single-cycle result and flags for every opcode except MUL
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res           = add_full[WIDTH-1:0];
                alu_flags[FLAG_C] = add_full[WIDTH];
                alu_flags[FLAG_V] = msb_carry_in ^ add_full[WIDTH];
            end
            OP_AND: alu_res = acc & b_in;
            OP_OR:  alu_res = acc | b_in;
            OP_XOR: alu_res = acc ^ b_in;
            OP_LD:  alu_res = b_in;
            OP_SHL: begin
                alu_res           = {acc[WIDTH-2:0], 1'b0};
                alu_flags[FLAG_C] = acc[WIDTH-1];
                alu_flags[FLAG_V] = acc[WIDTH-1] ^ acc[WIDTH-2];
            end
            default: alu_res = acc;
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
    end

    // Multiply commit value: low half kept, C and V flag a lost upper half
    always_comb begin
        mul_res           = mul_prod_next[WIDTH-1:0];
        mul_flags         = '0;
        mul_flags[FLAG_C] = |mul_prod_next[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_V] = |mul_prod_next[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (mul_res == '0);
        mul_flags[FLAG_N] = mul_res[WIDTH-1];
    end

    // Next-state and control decode; clear overrides everything and aborts a multiply
    always_comb begin
        next_state = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        alu_commit = 1'b0;
        mul_commit = 1'b0;
        if (clr_in) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        if (op == OP_MUL) begin
                            mul_load   = 1'b1;
                            next_state = ST_MUL_RUN;
                        end else begin
                            alu_commit = 1'b1;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        mul_commit = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Accumulator, flags and done pulse; only commits or clear change them
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc   <= '0;
            flags <= '0;
            done  <= 1'b0;
        end else begin
            done <= alu_commit | mul_commit;
            if (clr_in) begin
                acc   <= '0;
                flags <= CLR_FLAGS;
            end else if (alu_commit) begin
                acc   <= alu_res;
                flags <= alu_flags;
            end else if (mul_commit) begin
                acc   <= mul_res;
                flags <= mul_flags;
            end
        end
    end

    acc_alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clr       (clr_in),
        .load      (mul_load),
        .step      (mul_step),
        .a         (acc),
        .b         (b_in),
        .prod_next (mul_prod_next),
        .last      (mul_last)
    );

    assign acc_out      = acc;
    assign carry_out    = flags[FLAG_C];
    assign overflow_out = flags[FLAG_V];
    assign zero_out     = flags[FLAG_Z];
    assign neg_out      = flags[FLAG_N];
    assign busy_out     = (state == ST_MUL_RUN);
    assign done_out     = done;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq: an 8-bit instance for the main sequence and
// a 16-bit instance for the wide multiply. Expected values are hand-computed.
module tb_acc_alu_seq;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, clr8;
    logic [2:0]  ctl8;
    logic [7:0]  b8;
    logic [7:0]  acc8;
    logic        c8, v8, z8, n8, busy8, done8;
    logic        start16, clr16;
    logic [2:0]  ctl16;
    logic [15:0] b16;
    logic [15:0] acc16;
    logic        c16, v16, z16, n16, busy16, done16;

    int vectors = 0;
    int miscompares = 0;

    int busy_cycles;
    bit acc_held;
    bit got_done;
    bit done_seen;

    wire [3:0] flags8  = {c8, v8, z8, n8};
    wire [3:0] flags16 = {c16, v16, z16, n16};

    always #5 clk = ~clk;

    acc_alu_seq #(.WIDTH(8)) dut8 (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start8),
        .control_in   (ctl8),
        .b_in         (b8),
        .clr_in       (clr8),
        .acc_out      (acc8),
        .carry_out    (c8),
        .overflow_out (v8),
        .zero_out     (z8),
        .neg_out      (n8),
        .busy_out     (busy8),
        .done_out     (done8)
    );

    acc_alu_seq #(.WIDTH(16)) dut16 (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start16),
        .control_in   (ctl16),
        .b_in         (b16),
        .clr_in       (clr16),
        .acc_out      (acc16),
        .carry_out    (c16),
        .overflow_out (v16),
        .zero_out     (z16),
        .neg_out      (n16),
        .busy_out     (busy16),
        .done_out     (done16)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request on a falling edge and returns one cycle later, just after acceptance
    task automatic applyStimulus(input bit wide, input logic [2:0] op, input logic [15:0] b);
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1;
            ctl16   = op;
            b16     = b;
        end else begin
            start8 = 1'b1;
            ctl8   = op;
            b8     = b[7:0];
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles and watching the accumulator hold
    task automatic waitMul(input bit wide, input logic [15:0] held,
                           output int busy_n, output bit held_ok, output bit done_ok);
        busy_n  = 0;
        held_ok = 1'b1;
        done_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wide ? done16 : done8) begin
                done_ok = 1'b1;
                break;
            end
            if (wide ? busy16 : busy8) busy_n++;
            if ((wide ? acc16 : {8'h00, acc8}) !== held) held_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; clr8 = 1'b0; ctl8 = '0; b8 = '0;
        start16 = 1'b0; clr16 = 1'b0; ctl16 = '0; b16 = '0;

        #12;
        checkOutput("reset_acc",   {8'h00, acc8}, 16'h0000);
        checkOutput("reset_flags", {12'h0, flags8}, 16'h0000);
        checkOutput("reset_busy",  {15'h0, busy8}, 16'h0000);
        checkOutput("reset_done",  {15'h0, done8}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD 7F then ADD 01: signed overflow into the sign bit
        applyStimulus(0, OP_LD, 16'h007F);
        checkOutput("ld7f_acc",  {8'h00, acc8}, 16'h007F);
        checkOutput("ld7f_done", {15'h0, done8}, 16'h0001);
        applyStimulus(0, OP_ADD, 16'h0001);
        checkOutput("add_acc",   {8'h00, acc8}, 16'h0080);
        checkOutput("add_flags", {12'h0, flags8}, 16'h0005);
        checkOutput("add_done",  {15'h0, done8}, 16'h0001);
        @(negedge clk);
        checkOutput("add_done_pulse", {15'h0, done8}, 16'h0000);

        // SUB to zero (no borrow), then SUB through zero (borrow)
        applyStimulus(0, OP_LD, 16'h0005);
        applyStimulus(0, OP_SUB, 16'h0005);
        checkOutput("sub0_acc",   {8'h00, acc8}, 16'h0000);
        checkOutput("sub0_flags", {12'h0, flags8}, 16'h000A);
        applyStimulus(0, OP_SUB, 16'h0001);
        checkOutput("subff_acc",   {8'h00, acc8}, 16'h00FF);
        checkOutput("subff_flags", {12'h0, flags8}, 16'h0001);

        // SHL twice from C0
        applyStimulus(0, OP_LD, 16'h00C0);
        applyStimulus(0, OP_SHL, 16'h0000);
        checkOutput("shl1_acc",   {8'h00, acc8}, 16'h0080);
        checkOutput("shl1_flags", {12'h0, flags8}, 16'h0009);
        applyStimulus(0, OP_SHL, 16'h0000);
        checkOutput("shl2_acc",   {8'h00, acc8}, 16'h0000);
        checkOutput("shl2_flags", {12'h0, flags8}, 16'h000E);

        // MUL 0C x 0B = 84, with an ADD request ignored mid-run
        applyStimulus(0, OP_LD, 16'h000C);
        applyStimulus(0, OP_MUL, 16'h000B);
        checkOutput("mul1_busy_start", {15'h0, busy8}, 16'h0001);
        @(negedge clk);
        start8 = 1'b1; ctl8 = OP_ADD; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        waitMul(0, 16'h000C, busy_cycles, acc_held, got_done);
        checkOutput("mul1_done",       {15'h0, got_done}, 16'h0001);
        checkOutput("mul1_busy_rest",  busy_cycles[15:0], 16'd6);
        checkOutput("mul1_acc_held",   {15'h0, acc_held}, 16'h0001);
        checkOutput("mul1_acc",        {8'h00, acc8}, 16'h0084);
        checkOutput("mul1_flags",      {12'h0, flags8}, 16'h0001);
        checkOutput("mul1_busy_done",  {15'h0, busy8}, 16'h0000);

        // Back-to-back: LOAD accepted in the done cycle, then MUL 20 x 10 overflows
        start8 = 1'b1; ctl8 = OP_LD; b8 = 8'h20;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("b2b_acc",  {8'h00, acc8}, 16'h0020);
        checkOutput("b2b_done", {15'h0, done8}, 16'h0001);
        applyStimulus(0, OP_MUL, 16'h0010);
        waitMul(0, 16'h0020, busy_cycles, acc_held, got_done);
        checkOutput("mul2_done",     {15'h0, got_done}, 16'h0001);
        checkOutput("mul2_busy",     busy_cycles[15:0], 16'd8);
        checkOutput("mul2_acc_held", {15'h0, acc_held}, 16'h0001);
        checkOutput("mul2_acc",      {8'h00, acc8}, 16'h0000);
        checkOutput("mul2_flags",    {12'h0, flags8}, 16'h000E);

        // Clear during the third multiply cycle aborts with no done
        applyStimulus(0, OP_LD, 16'h000C);
        applyStimulus(0, OP_MUL, 16'h000B);
        @(negedge clk);
        @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        checkOutput("clr_acc",   {8'h00, acc8}, 16'h0000);
        checkOutput("clr_flags", {12'h0, flags8}, 16'h0002);
        checkOutput("clr_busy",  {15'h0, busy8}, 16'h0000);
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8) done_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("clr_no_done", {15'h0, done_seen}, 16'h0000);

        // Asynchronous reset between edges mid-multiply
        applyStimulus(0, OP_LD, 16'h0080);
        applyStimulus(0, OP_MUL, 16'h0003);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_acc",   {8'h00, acc8}, 16'h0000);
        checkOutput("arst_flags", {12'h0, flags8}, 16'h0000);
        checkOutput("arst_busy",  {15'h0, busy8}, 16'h0000);
        checkOutput("arst_done",  {15'h0, done8}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8) done_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("arst_no_done", {15'h0, done_seen}, 16'h0000);

        // 16-bit instance: 0100 x 0100 = 1_0000, low half zero
        applyStimulus(1, OP_LD, 16'h0100);
        checkOutput("w16_ld", acc16, 16'h0100);
        applyStimulus(1, OP_MUL, 16'h0100);
        waitMul(1, 16'h0100, busy_cycles, acc_held, got_done);
        checkOutput("w16_done",     {15'h0, got_done}, 16'h0001);
        checkOutput("w16_busy",     busy_cycles[15:0], 16'd16);
        checkOutput("w16_acc_held", {15'h0, acc_held}, 16'h0001);
        checkOutput("w16_acc",      acc16, 16'h0000);
        checkOutput("w16_flags",    {12'h0, flags16}, 16'h000E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
